// File: rtl/uart_pkg.sv
// Shared UART types and constants, used by the transmit and receive paths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus-side view of the UART transmitter: write strobe/data in, serial line and status out.
// Latency: n/a (wiring only).
// Backpressure: none on the wire; writers watch tx_full, drops are flagged on tx_ovf.
// Ports: master = bus/host side, slave = uart_tx_fifo.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                      tx_wen;
    logic [UART_DATA_BITS-1:0] din;
    logic                      tx;
    logic                      tx_full;
    logic                      tx_empty;
    logic                      tx_busy;
    logic                      tx_ovf;
    logic [CW-1:0]             tx_count;

    modport master (
        output tx_wen, din,
        input  tx, tx_full, tx_empty, tx_busy, tx_ovf, tx_count
    );

    modport slave (
        input  tx_wen, din,
        output tx, tx_full, tx_empty, tx_busy, tx_ovf, tx_count
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and first-word-fall-through read data.
// Latency: a pushed word is visible on pop_dat the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty (both judged on registered count).
// Ports: clk/rst, push/push_dat, pop/pop_dat, full, empty, count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Fullness is taken from the registered count, so a write into a full
    // FIFO is refused even if a pop frees a slot on the same edge.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes written by the bus are queued and sent as 8N1 frames, LSB first.
// Latency: write into an empty, idle block -> start bit on tx one cycle after the write edge.
// Backpressure: none; writes while full are dropped and flagged with a one-cycle tx_ovf.
// Ports: clk, Rst (sync, active-high), bus (slave modport: tx_wen/din in; tx and status out).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic           clk,
    input  logic           Rst,
    uart_tx_fifo_if.slave  bus
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state, state_nxt;
    logic [BW-1:0]             baud_cnt, baud_nxt;
    logic [2:0]                bit_cnt, bit_nxt;
    logic [UART_DATA_BITS-1:0] shift, shift_nxt;
    logic                      tx_q, tx_nxt;

    logic                      fifo_pop;
    logic [UART_DATA_BITS-1:0] fifo_dat;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                      bit_end;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (Rst),
        .push     (bus.tx_wen),
        .push_dat (bus.din),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (Rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            tx_q     <= tx_nxt;
        end
    end

    // tx_nxt is the line level for the bit that begins on the coming edge,
    // so tx is registered yet changes exactly on bit boundaries.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        tx_nxt    = tx_q;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                tx_nxt   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_dat;
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    tx_nxt    = shift[0];
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        bit_nxt   = bit_cnt + 3'd1;
                        shift_nxt = {1'b0, shift[UART_DATA_BITS-1:1]};
                        tx_nxt    = shift[1];
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    // Chain straight into the next start bit to keep frames contiguous.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_nxt = fifo_dat;
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.tx       = tx_q;
    assign bus.tx_busy  = (state != IDLE);
    assign bus.tx_full  = fifo_full;
    assign bus.tx_empty = fifo_empty && (state == IDLE);
    assign bus.tx_count = fifo_count;
    assign bus.tx_ovf   = bus.tx_wen && fifo_full && !Rst;

endmodule
